// File: rtl/day5_multiword_adder_seq.sv
// ---------------------------------------------------------------------------
// day5_multiword_adder_seq
// Runs one OP_W-bit add (OP_W = SLICE_W*NUM_SLICES) through an external
// SLICE_W-bit combinational ripple adder, one slice per cycle, LSB first.
// The carry is chained between slices; the full sum and carry-out are
// assembled here and held until the next completion.
//
// Ports
//   clk, reset    single clock, synchronous active-high reset
//   valid_i       request: a_in/b_in/c_in valid this cycle
//   ready_o       high in IDLE; a request is accepted when valid_i && ready_o
//   a_in, b_in    OP_W-bit operands, sampled on accept
//   c_in          carry-in to slice 0, sampled on accept
//   add_a_o       current slice of A to the external adder (0 outside RUN)
//   add_b_o       current slice of B to the external adder (0 outside RUN)
//   add_c_o       chained carry to the external adder (0 outside RUN)
//   add_sum_i     slice sum from the external adder
//   add_carry_i   per-bit carries from the adder; MSB is the slice carry-out
//   sum_o         OP_W-bit result, held until the next completion
//   carry_o       final carry-out, held with sum_o
//   busy_o        high in RUN and DONE
//   done_o        one-cycle pulse when sum_o/carry_o are newly valid
// ---------------------------------------------------------------------------
module day5_multiword_adder_seq #(
  parameter int unsigned SLICE_W    = 4,
  parameter int unsigned NUM_SLICES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [SLICE_W*NUM_SLICES-1:0]   a_in,
  input  logic [SLICE_W*NUM_SLICES-1:0]   b_in,
  input  logic                            c_in,
  output logic [SLICE_W-1:0]              add_a_o,
  output logic [SLICE_W-1:0]              add_b_o,
  output logic                            add_c_o,
  input  logic [SLICE_W-1:0]              add_sum_i,
  input  logic [SLICE_W-1:0]              add_carry_i,
  output logic [SLICE_W*NUM_SLICES-1:0]   sum_o,
  output logic                            carry_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned OP_W  = SLICE_W * NUM_SLICES;
  localparam int unsigned IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [OP_W-1:0]    op_a_q,  op_a_d;
  logic [OP_W-1:0]    op_b_q,  op_b_d;
  logic [OP_W-1:0]    acc_q,   acc_d;
  logic               cry_q,   cry_d;
  logic [OP_W-1:0]    sum_q,   sum_d;
  logic               carry_q, carry_d;
  logic               ready_q, ready_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [SLICE_W-1:0] add_a_q, add_a_d;
  logic [SLICE_W-1:0] add_b_q, add_b_d;
  logic               add_c_q, add_c_d;

  // Only the MSB of the adder carry vector is meaningful here.
  logic unused_carry_bits;
  assign unused_carry_bits = ^add_carry_i;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      cry_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      add_a_q <= '0;
      add_b_q <= '0;
      add_c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      cry_q   <= cry_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      add_c_q <= add_c_d;
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    cry_d   = cry_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    add_a_d = '0;
    add_b_d = '0;
    add_c_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          op_a_d  = a_in;
          op_b_d  = b_in;
          cry_d   = c_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d[idx_q*SLICE_W +: SLICE_W] = add_sum_i;
        cry_d = add_carry_i[SLICE_W-1];
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // acc_d already holds this last slice.
          sum_d   = acc_d;
          carry_d = add_carry_i[SLICE_W-1];
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are flop outputs
    // that line up with the state they describe.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    if (state_d == S_RUN) begin
      add_a_d = op_a_d[idx_d*SLICE_W +: SLICE_W];
      add_b_d = op_b_d[idx_d*SLICE_W +: SLICE_W];
      add_c_d = cry_d;
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign add_a_o = add_a_q;
  assign add_b_o = add_b_q;
  assign add_c_o = add_c_q;

endmodule

// File: tb/tb_day5_multiword_adder_seq.sv
// ---------------------------------------------------------------------------
// tb_day5_multiword_adder_seq
// Self-checking bench: a 4-bit ripple adder sits between the add_* ports;
// results are compared with plain a+b+c arithmetic.
// ---------------------------------------------------------------------------
module tb_day5_multiword_adder_seq;

  localparam int unsigned SLICE_W    = 4;
  localparam int unsigned NUM_SLICES = 4;
  localparam int unsigned OP_W       = SLICE_W * NUM_SLICES;

  logic                clk;
  logic                reset;
  logic                valid_i;
  logic                ready_o;
  logic [OP_W-1:0]     a_in;
  logic [OP_W-1:0]     b_in;
  logic                c_in;
  logic [SLICE_W-1:0]  add_a_o;
  logic [SLICE_W-1:0]  add_b_o;
  logic                add_c_o;
  logic [SLICE_W-1:0]  add_sum_i;
  logic [SLICE_W-1:0]  add_carry_i;
  logic [OP_W-1:0]     sum_o;
  logic                carry_o;
  logic                busy_o;
  logic                done_o;

  int n_checks;
  int n_fail;

  day5_multiword_adder_seq #(
    .SLICE_W    (SLICE_W),
    .NUM_SLICES (NUM_SLICES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .a_in        (a_in),
    .b_in        (b_in),
    .c_in        (c_in),
    .add_a_o     (add_a_o),
    .add_b_o     (add_b_o),
    .add_c_o     (add_c_o),
    .add_sum_i   (add_sum_i),
    .add_carry_i (add_carry_i),
    .sum_o       (sum_o),
    .carry_o     (carry_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ripple carry slice adder between the add_* ports.
  always_comb begin
    logic rc;
    rc = add_c_o;
    add_sum_i   = '0;
    add_carry_i = '0;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      add_sum_i[i]   = add_a_o[i] ^ add_b_o[i] ^ rc;
      rc             = (add_a_o[i] & add_b_o[i]) | (rc & (add_a_o[i] ^ add_b_o[i]));
      add_carry_i[i] = rc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first RUN cycle.
  task automatic start_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic c);
    check("ready_before_accept", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    a_in    = a;
    b_in    = b;
    c_in    = c;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    a_in    = OP_W'($urandom);
    b_in    = OP_W'($urandom);
    c_in    = 1'($urandom);
  endtask

  // Collects the slice stream until done_o, returns at the negedge after done.
  task automatic finish_op(output logic [OP_W-1:0] aseq, output logic [OP_W-1:0] bseq,
                           output logic [NUM_SLICES-1:0] cseq, output int lat,
                           output logic [OP_W-1:0] s, output logic co);
    int nrun;
    aseq = '0;
    bseq = '0;
    cseq = '0;
    lat  = 1;
    nrun = 0;
    while (!done_o && lat < 20) begin
      if (busy_o && nrun < int'(NUM_SLICES)) begin
        aseq[nrun*SLICE_W +: SLICE_W] = add_a_o;
        bseq[nrun*SLICE_W +: SLICE_W] = add_b_o;
        cseq[nrun] = add_c_o;
        nrun++;
      end
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(done_o), 32'd1);
    check("add_a_zero_in_done", 32'(add_a_o), 32'd0);
    check("add_c_zero_in_done", 32'(add_c_o), 32'd0);
    s  = sum_o;
    co = carry_o;
    @(negedge clk);
    check("done_single_cycle", 32'(done_o), 32'd0);
  endtask

  typedef struct {
    logic [OP_W-1:0]       a;
    logic [OP_W-1:0]       b;
    logic                  c;
    logic [OP_W-1:0]       sum;
    logic                  carry;
    logic [NUM_SLICES-1:0] cseq;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [OP_W-1:0]       aseq, bseq, s;
    logic [NUM_SLICES-1:0] cseq;
    logic                  co;
    logic [OP_W:0]         ref_v;
    logic [OP_W-1:0]       ra, rb;
    logic                  rcin;
    logic                  saw_done;
    int                    lat;

    n_checks = 0;
    n_fail   = 0;

    // cseq bit i is add_c_o in RUN cycle i.
    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, c: 1'b0, sum: 16'h0000, carry: 1'b1, cseq: 4'b1110};
    vecs[1] = '{a: 16'h1234, b: 16'h4321, c: 1'b1, sum: 16'h5556, carry: 1'b0, cseq: 4'b0001};
    vecs[2] = '{a: 16'h00FF, b: 16'h0001, c: 1'b0, sum: 16'h0100, carry: 1'b0, cseq: 4'b0110};

    reset   = 1'b1;
    valid_i = 1'b0;
    a_in    = '0;
    b_in    = '0;
    c_in    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_sum", 32'(sum_o), 32'd0);
    check("rst_carry", 32'(carry_o), 32'd0);
    check("rst_add_a", 32'(add_a_o), 32'd0);
    check("rst_add_c", 32'(add_c_o), 32'd0);

    // Directed vectors.
    for (int v = 0; v < 3; v++) begin
      start_op(vecs[v].a, vecs[v].b, vecs[v].c);
      finish_op(aseq, bseq, cseq, lat, s, co);
      check("vec_sum", 32'(s), 32'(vecs[v].sum));
      check("vec_carry", 32'(co), 32'(vecs[v].carry));
      check("vec_latency", 32'(lat), 32'd5);
      check("vec_add_a_seq", 32'(aseq), 32'(vecs[v].a));
      check("vec_add_b_seq", 32'(bseq), 32'(vecs[v].b));
      check("vec_add_c_seq", 32'(cseq), 32'(vecs[v].cseq));
    end

    // Reset during the second RUN cycle aborts the op.
    start_op(16'h1357, 16'h2468, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_sum", 32'(sum_o), 32'd0);
    check("abort_carry", 32'(carry_o), 32'd0);
    reset    = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    // valid_i held high with new operands through the whole op.
    valid_i = 1'b1;
    a_in    = 16'h0F0F;
    b_in    = 16'h1111;
    c_in    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_in = 16'hA5A5;
    b_in = 16'h5A5A;
    c_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("hold_ready_low", 32'(ready_o), 32'd0);
      check("hold_busy", 32'(busy_o), 32'd1);
      check("hold_done_timing", 32'(done_o), (k == 4) ? 32'd1 : 32'd0);
      if (k < 4) @(negedge clk);
    end
    check("hold_first_sum", 32'(sum_o), 32'h2020);
    check("hold_first_carry", 32'(carry_o), 32'd0);
    @(negedge clk);
    check("hold_ready_idle", 32'(ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    finish_op(aseq, bseq, cseq, lat, s, co);
    check("hold_second_sum", 32'(s), 32'h0000);
    check("hold_second_carry", 32'(co), 32'd1);
    check("hold_second_add_a", 32'(aseq), 32'hA5A5);

    // Random back-to-back operations against plain arithmetic.
    for (int n = 0; n < 1000; n++) begin
      ra   = OP_W'($urandom);
      rb   = OP_W'($urandom);
      rcin = 1'($urandom);
      if (n % 50 == 0) ra = '1;
      if (n % 70 == 0) rb = '1;
      ref_v = (OP_W+1)'(ra) + (OP_W+1)'(rb) + (OP_W+1)'(rcin);
      start_op(ra, rb, rcin);
      finish_op(aseq, bseq, cseq, lat, s, co);
      check("rand_result", 32'({co, s}), 32'(ref_v));
      check("rand_latency", 32'(lat), 32'd5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
